// File: rtl/clean_mode_ctrl.sv
// Cleaning-mode controller: turns key pulses into self/manual clean levels, a seconds display and an abort pulse.
// All outputs are registered; each mode change appears one cycle after the request edge.
module clean_mode_ctrl #(
  parameter int TICKS_PER_SEC  = 100,
  parameter int SELF_CLEAN_SEC = 180,
  parameter int MANUAL_MAX_SEC = 600
) (
  input  logic       clk_100Hz,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       self_clean_req,
  input  logic       manual_clean_req,
  input  logic       cancel_req,
  output logic       self_clean,
  output logic       manual_clean,
  output logic       busy,
  output logic       aborted,
  output logic [9:0] disp_sec
);

  localparam int TW = $clog2(TICKS_PER_SEC);
  localparam logic [TW-1:0] TICK_MAX   = TW'(TICKS_PER_SEC - 1);
  localparam logic [9:0]    SELF_SEC   = 10'(SELF_CLEAN_SEC);
  localparam logic [9:0]    MAN_LAST   = 10'(MANUAL_MAX_SEC - 1);

  typedef enum logic [1:0] {S_IDLE, S_SELF, S_MANUAL} state_t;

  state_t        state_q;
  logic [TW-1:0] tick_q;
  logic          self_q, manual_q, busy_q, aborted_q;
  logic [9:0]    disp_q;

  assign self_clean   = self_q;
  assign manual_clean = manual_q;
  assign busy         = busy_q;
  assign aborted      = aborted_q;
  assign disp_sec     = disp_q;

  always_ff @(posedge clk_100Hz) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      self_q    <= 1'b0;
      manual_q  <= 1'b0;
      busy_q    <= 1'b0;
      aborted_q <= 1'b0;
      disp_q    <= '0;
    end else begin
      aborted_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable && self_clean_req) begin
            state_q <= S_SELF;
            tick_q  <= '0;
            disp_q  <= SELF_SEC;
            self_q  <= 1'b1;
            busy_q  <= 1'b1;
          end else if (enable && manual_clean_req) begin
            state_q  <= S_MANUAL;
            tick_q   <= '0;
            disp_q   <= '0;
            manual_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_SELF: begin
          if (cancel_req || !enable) begin
            state_q   <= S_IDLE;
            aborted_q <= 1'b1;
            self_q    <= 1'b0;
            busy_q    <= 1'b0;
            disp_q    <= '0;
          end else if (tick_q == TICK_MAX) begin
            tick_q <= '0;
            // Last second of the countdown ends the run without an abort flag.
            if (disp_q == 10'd1) begin
              state_q <= S_IDLE;
              self_q  <= 1'b0;
              busy_q  <= 1'b0;
              disp_q  <= '0;
            end else begin
              disp_q <= disp_q - 10'd1;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        S_MANUAL: begin
          if (cancel_req || !enable) begin
            state_q   <= S_IDLE;
            aborted_q <= 1'b1;
            manual_q  <= 1'b0;
            busy_q    <= 1'b0;
            disp_q    <= '0;
          end else if (manual_clean_req ||
                       (tick_q == TICK_MAX && disp_q == MAN_LAST)) begin
            state_q  <= S_IDLE;
            manual_q <= 1'b0;
            busy_q   <= 1'b0;
            disp_q   <= '0;
          end else if (tick_q == TICK_MAX) begin
            tick_q <= '0;
            disp_q <= disp_q + 10'd1;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          self_q   <= 1'b0;
          manual_q <= 1'b0;
          busy_q   <= 1'b0;
          disp_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clean_mode_ctrl.sv
// Bench for clean_mode_ctrl: vector table, multi-cycle run sequences and random traffic against a cycle-count model.
module tb_clean_mode_ctrl;

  localparam int TPS  = 4;
  localparam int SELF = 3;
  localparam int MAX  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, en = 1'b0, sreq = 1'b0, mreq = 1'b0, creq = 1'b0;
  logic       self_clean, manual_clean, busy, aborted;
  logic [9:0] disp_sec;

  int errors = 0;
  int checks = 0;

  // Model: mode (0 idle, 1 self, 2 manual) and cycles elapsed since entry.
  int   m_mode = 0;
  int   m_n    = 0;
  logic m_ab   = 1'b0;

  clean_mode_ctrl #(.TICKS_PER_SEC(TPS), .SELF_CLEAN_SEC(SELF), .MANUAL_MAX_SEC(MAX)) dut (
    .clk_100Hz(clk), .rst_n(rst_n), .enable(en), .self_clean_req(sreq),
    .manual_clean_req(mreq), .cancel_req(creq), .self_clean(self_clean),
    .manual_clean(manual_clean), .busy(busy), .aborted(aborted), .disp_sec(disp_sec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, e, s, m, c;
    logic [13:0] exp;
  } vec_t;

  function automatic vec_t mk(logic r, logic e, logic s, logic m, logic c,
                              logic so, logic mo, logic bo, logic ao, int d);
    vec_t v;
    v.r = r; v.e = e; v.s = s; v.m = m; v.c = c;
    v.exp = {so, mo, bo, ao, 10'(d)};
    return v;
  endfunction

  function automatic logic [13:0] dut_out();
    return {self_clean, manual_clean, busy, aborted, disp_sec};
  endfunction

  function automatic logic [13:0] model_out();
    int d;
    d = (m_mode == 1) ? SELF - m_n / TPS : (m_mode == 2) ? m_n / TPS : 0;
    return {m_mode == 1, m_mode == 2, m_mode != 0, m_ab, 10'(d)};
  endfunction

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {self,man,busy,ab,disp}=%b_%0d required %b_%0d at %0t",
               name, act[13:10], act[9:0], exp[13:10], exp[9:0], $time);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_mode = 0; m_ab = 1'b0;
    end else begin
      m_ab = 1'b0;
      if (m_mode == 0) begin
        if (en && sreq)      begin m_mode = 1; m_n = 0; end
        else if (en && mreq) begin m_mode = 2; m_n = 0; end
      end else if (creq || !en) begin
        m_mode = 0; m_ab = 1'b1;
      end else begin
        m_n++;
        if (m_mode == 1 && m_n == SELF * TPS) m_mode = 0;
        else if (m_mode == 2 && (mreq || m_n == MAX * TPS)) m_mode = 0;
      end
    end
  endtask

  task automatic step(input string name);
    model_edge();
    @(posedge clk);
    #1;
    chk(name, dut_out(), model_out());
  endtask

  task automatic drive(input logic r, input logic e, input logic s, input logic m, input logic c);
    rst_n = r; en = e; sreq = s; mreq = m; creq = c;
  endtask

  vec_t tbl[22];

  initial begin
    int cnt, g;
    bit ab_seen;

    tbl[0]  = mk(0,0,0,0,0, 0,0,0,0,0);
    tbl[1]  = mk(1,1,0,0,1, 0,0,0,0,0);
    tbl[2]  = mk(1,0,1,0,0, 0,0,0,0,0);
    tbl[3]  = mk(1,0,0,1,0, 0,0,0,0,0);
    tbl[4]  = mk(1,1,1,1,0, 1,0,1,0,3);
    tbl[5]  = mk(1,1,0,1,0, 1,0,1,0,3);
    tbl[6]  = mk(1,1,0,0,0, 1,0,1,0,3);
    tbl[7]  = mk(1,1,1,0,0, 1,0,1,0,3);
    tbl[8]  = mk(1,1,0,0,0, 1,0,1,0,2);
    tbl[9]  = mk(1,1,0,0,1, 0,0,0,1,0);
    tbl[10] = mk(1,1,0,0,0, 0,0,0,0,0);
    tbl[11] = mk(1,1,0,1,0, 0,1,1,0,0);
    tbl[12] = mk(1,1,0,0,0, 0,1,1,0,0);
    tbl[13] = mk(1,1,0,0,0, 0,1,1,0,0);
    tbl[14] = mk(1,1,0,0,0, 0,1,1,0,0);
    tbl[15] = mk(1,1,0,0,0, 0,1,1,0,1);
    tbl[16] = mk(1,0,0,0,0, 0,0,0,1,0);
    tbl[17] = mk(1,1,0,1,0, 0,1,1,0,0);
    tbl[18] = mk(1,1,0,1,0, 0,0,0,0,0);
    tbl[19] = mk(1,1,1,0,0, 1,0,1,0,3);
    tbl[20] = mk(0,1,0,0,0, 0,0,0,0,0);
    tbl[21] = mk(1,1,0,0,0, 0,0,0,0,0);

    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].m, tbl[i].c);
      step("model");
      chk($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end

    // Full self-clean run after reset: high for SELF*TPS cycles, no abort.
    drive(0, 1, 0, 0, 0); step("rst");
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step("idle");
    drive(1, 1, 1, 0, 0); step("self_start");
    drive(1, 1, 0, 0, 0);
    cnt = 0; g = 0; ab_seen = 0;
    while (self_clean && g < 100) begin
      cnt++; g++;
      step("self_run");
      if (aborted) ab_seen = 1;
    end
    chk("self_high_cycles", 14'(cnt), 14'(SELF * TPS));
    chk("self_no_abort", 14'(ab_seen), 14'd0);

    // Manual timeout: high for MAX*TPS cycles.
    drive(1, 1, 0, 1, 0); step("man_start");
    drive(1, 1, 0, 0, 0);
    cnt = 0; g = 0; ab_seen = 0;
    while (manual_clean && g < 100) begin
      cnt++; g++;
      step("man_run");
      if (aborted) ab_seen = 1;
    end
    chk("man_timeout_cycles", 14'(cnt), 14'(MAX * TPS));
    chk("man_no_abort", 14'(ab_seen), 14'd0);

    // Manual toggle after 3 cycles.
    drive(1, 1, 0, 1, 0); step("man_start2");
    drive(1, 1, 0, 0, 0); step("man_c1"); step("man_c2");
    drive(1, 1, 0, 1, 0); step("man_toggle");
    chk("man_toggled_off", dut_out(), 14'd0);
    drive(1, 1, 0, 0, 0); step("idle2");

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 200) != 0, ($urandom % 30) != 0, ($urandom % 12) == 0,
            ($urandom % 10) == 0, ($urandom % 25) == 0);
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
